// File: rtl/line_fill_engine_if.sv
// Bundle of the cache-side request/fill beats and the memory read channel for line_fill_engine.
// master = the engine's view, slave = the cache + backing-memory environment.
interface line_fill_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  fill_valid;
  logic [DATA_WIDTH-1:0] fill_data;
  logic [1:0]            fill_idx;
  logic                  fill_last;
  logic                  fill_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  mem_rsp_err;

  modport master (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output req_ready, fill_valid, fill_data, fill_idx, fill_last, fill_err,
           mem_req_valid, mem_req_addr
  );

  modport slave (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  req_ready, fill_valid, fill_data, fill_idx, fill_last, fill_err,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/line_fill_engine.sv
// Splits one cache line-fill into four single-word memory reads and returns an ordered beat stream.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN: fetch/return the requested word first, wrapping.
module line_fill_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_WORDS      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  line_fill_engine_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] WORDS     = 3'(LINE_WORDS);
  localparam logic [2:0] LAST_WORD = WORDS - 3'd1;
  localparam logic [2:0] MAX_OUT   = 3'(MAX_OUTSTANDING);

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] START_MASK = 2'b11;
`else
  localparam logic [1:0] START_MASK = 2'b00;
`endif

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-3:0] base_reg, base_next;
  logic [1:0]            start_reg, start_next;
  logic [2:0]            issued_reg, issued_next;
  logic [2:0]            received_reg, received_next;
  logic [2:0]            outstanding_reg, outstanding_next;
  logic                  sticky_err_reg, sticky_err_next;

  logic                  fill_valid_reg, fill_valid_next;
  logic [DATA_WIDTH-1:0] fill_data_reg, fill_data_next;
  logic [1:0]            fill_idx_reg, fill_idx_next;
  logic                  fill_last_reg, fill_last_next;
  logic                  fill_err_reg, fill_err_next;

  logic mem_req_valid_c;
  logic mem_hs;
  logic rsp_acc;
  logic rsp_last;

  // Request valid depends only on registered state, so it and the address hold while stalled.
  assign mem_req_valid_c = (state_reg == ISSUE) && (issued_reg < WORDS) &&
                           (outstanding_reg < MAX_OUT);
  assign mem_hs   = mem_req_valid_c && bus.mem_req_ready;
  assign rsp_acc  = bus.mem_rsp_valid && (outstanding_reg != 3'd0);
  assign rsp_last = rsp_acc && (received_reg == LAST_WORD);

  always_comb begin
    state_next       = state_reg;
    base_next        = base_reg;
    start_next       = start_reg;
    issued_next      = issued_reg;
    received_next    = received_reg;
    outstanding_next = outstanding_reg;
    sticky_err_next  = sticky_err_reg;

    if (mem_hs) begin
      issued_next = issued_reg + 3'd1;
    end
    if (rsp_acc) begin
      received_next   = received_reg + 3'd1;
      sticky_err_next = sticky_err_reg | bus.mem_rsp_err;
    end
    case ({mem_hs, rsp_acc})
      2'b10:   outstanding_next = outstanding_reg + 3'd1;
      2'b01:   outstanding_next = outstanding_reg - 3'd1;
      default: outstanding_next = outstanding_reg;
    endcase

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next      = ISSUE;
          base_next       = bus.req_addr[ADDR_WIDTH-1:2];
          start_next      = bus.req_addr[1:0] & START_MASK;
          issued_next     = 3'd0;
          received_next   = 3'd0;
          sticky_err_next = 1'b0;
        end
      end
      ISSUE: begin
        if (rsp_last) begin
          state_next = IDLE;
        end else if (mem_hs && (issued_reg == LAST_WORD)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (rsp_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat registers: data/idx hold between beats, last/err are strictly one-cycle qualifiers.
  always_comb begin
    fill_valid_next = rsp_acc;
    fill_data_next  = fill_data_reg;
    fill_idx_next   = fill_idx_reg;
    fill_last_next  = rsp_last;
    fill_err_next   = rsp_last && (sticky_err_reg || bus.mem_rsp_err);
    if (rsp_acc) begin
      fill_data_next = bus.mem_rsp_data;
      fill_idx_next  = start_reg + received_reg[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      base_reg        <= '0;
      start_reg       <= 2'd0;
      issued_reg      <= 3'd0;
      received_reg    <= 3'd0;
      outstanding_reg <= 3'd0;
      sticky_err_reg  <= 1'b0;
      fill_valid_reg  <= 1'b0;
      fill_data_reg   <= '0;
      fill_idx_reg    <= 2'd0;
      fill_last_reg   <= 1'b0;
      fill_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      base_reg        <= base_next;
      start_reg       <= start_next;
      issued_reg      <= issued_next;
      received_reg    <= received_next;
      outstanding_reg <= outstanding_next;
      sticky_err_reg  <= sticky_err_next;
      fill_valid_reg  <= fill_valid_next;
      fill_data_reg   <= fill_data_next;
      fill_idx_reg    <= fill_idx_next;
      fill_last_reg   <= fill_last_next;
      fill_err_reg    <= fill_err_next;
    end
  end

  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_req_addr  = {base_reg, start_reg + issued_reg[1:0]};
  assign bus.fill_valid    = fill_valid_reg;
  assign bus.fill_data     = fill_data_reg;
  assign bus.fill_idx      = fill_idx_reg;
  assign bus.fill_last     = fill_last_reg;
  assign bus.fill_err      = fill_err_reg;

endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine: memory BFM, beat monitor and a line-order reference model.
// Honours FILL_CRITICAL_WORD_FIRST_EN the same way as the design.
module tb_line_fill_engine;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  line_fill_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
    logic        err;
    logic        rdy;
    int          edge_n;
  } beat_t;

  pend_t       pend_q[$];
  beat_t       beats[$];
  logic [31:0] req_addrs[$];
  logic [31:0] stall_addrs[$];
  int          rsp_edges[$];

  int          ready_pct  = 100;
  int          lat_max    = 0;
  int          stall_left = 0;
  int          rsp_n      = 0;
  bit          stall_arm  = 0;
  bit          stalling   = 0;
  bit          hold_rsp   = 0;
  bit          stray_req  = 0;
  bit          rsp_real   = 0;
  logic [3:0]  err_mask   = 4'd0;
  logic [31:0] data_xor   = 32'd0;

  int checks   = 0;
  int failures = 0;

  // Memory BFM and beat monitor: observe at negedge, drive 1 time unit after posedge.
  initial begin
    beat_t b;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else begin
        if (bus.fill_valid) begin
          b.data = bus.fill_data; b.idx = bus.fill_idx; b.last = bus.fill_last;
          b.err = bus.fill_err; b.rdy = bus.req_ready; b.edge_n = cyc;
          beats.push_back(b);
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          req_addrs.push_back(bus.mem_req_addr);
          pend_q.push_back('{bus.mem_req_addr, cyc + 1 + int'($urandom_range(0, lat_max))});
        end
        if (bus.mem_req_valid && stalling) stall_addrs.push_back(bus.mem_req_addr);
        if (rsp_real) begin
          rsp_edges.push_back(cyc + 1);
          void'(pend_q.pop_front());
          rsp_n++;
        end
      end
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      rsp_real = 0;
      stalling = 0;
      if (!rst_n) begin
        bus.mem_req_ready = 1'b0;
      end else begin
        if (stall_arm && req_addrs.size() == 1 && bus.mem_req_valid) begin
          stall_arm  = 0;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          bus.mem_req_ready = 1'b0;
          stalling = 1;
          stall_left--;
        end else begin
          bus.mem_req_ready = ($urandom_range(1, 100) <= ready_pct);
        end
        if (!hold_rsp && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = pend_q[0].addr ^ data_xor;
          bus.mem_rsp_err   = (rsp_n < 4) ? err_mask[rsp_n] : 1'b0;
          rsp_real = 1;
        end else if (stray_req && pend_q.size() == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = $urandom;
          bus.mem_rsp_err   = 1'b1;
          stray_req = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    beats.delete();
    req_addrs.delete();
    rsp_edges.delete();
    stall_addrs.delete();
    rsp_n = 0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req_ready"},     bus.req_ready,     1);
    chk({nm, "_mem_req_valid"}, bus.mem_req_valid, 0);
    chk({nm, "_mem_req_addr"},  bus.mem_req_addr,  0);
    chk({nm, "_fill_valid"},    bus.fill_valid,    0);
    chk({nm, "_fill_data"},     bus.fill_data,     0);
    chk({nm, "_fill_idx"},      bus.fill_idx,      0);
    chk({nm, "_fill_last"},     bus.fill_last,     0);
    chk({nm, "_fill_err"},      bus.fill_err,      0);
  endtask

  task automatic do_req(input logic [31:0] a);
    int n;
    clear_logs();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("req_accept_in_time", (n < 100), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("first_mem_req_valid", bus.mem_req_valid, 1);
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (beats.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("beats_in_time", (beats.size() >= n), 1);
  endtask

  function automatic int start_of(input logic [31:0] a);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    return int'(a[1:0]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] a, input int k);
    logic [31:0] r;
    r = a;
    r[1:0] = 2'((start_of(a) + k) % 4);
    return r;
  endfunction

  // Reference: word k of the line is base*4 + (start+k) mod 4; error flag only on the 4th beat.
  task automatic check_fill(input logic [31:0] a, input string nm);
    logic [31:0] ea;
    wait_beats(4);
    repeat (2) @(posedge clk);
    chk({nm, "_beat_count"}, beats.size(), 4);
    chk({nm, "_req_count"},  req_addrs.size(), 4);
    for (int k = 0; k < 4; k++) begin
      ea = word_addr(a, k);
      if (k < req_addrs.size()) chk({nm, "_mem_addr"}, req_addrs[k], ea);
      if (k < beats.size()) begin
        chk({nm, "_idx"},  beats[k].idx,  ea[1:0]);
        chk({nm, "_data"}, beats[k].data, ea ^ data_xor);
        chk({nm, "_last"}, beats[k].last, (k == 3));
        chk({nm, "_err"},  beats[k].err,  (k == 3) ? (|err_mask) : 1'b0);
        if (k < rsp_edges.size()) chk({nm, "_beat_latency"}, beats[k].edge_n, rsp_edges[k]);
      end
    end
    if (beats.size() == 4) chk({nm, "_ready_with_last"}, beats[3].rdy, 1);
  endtask

  initial begin
    logic [31:0] a;
    int nl;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;

    // Reset with no stimulus, then a stray response.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    stray_req = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("stray_no_beat", beats.size(), 0);
    chk("stray_idle_ready", bus.req_ready, 1);

    // Zero-wait memory, data = address.
    ready_pct = 100; lat_max = 0; data_xor = 32'd0; err_mask = 4'd0;
    do_req(32'h103);
    check_fill(32'h103, "dir103");

    // Memory holds responses: only MAX_OUTSTANDING requests go out.
    hold_rsp = 1;
    do_req(32'h200);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("hold_hs_count", req_addrs.size(), MAXO);
    chk("hold_valid_low", bus.mem_req_valid, 0);
    hold_rsp = 0;
    check_fill(32'h200, "hold");

    // Three-cycle ready stall on the 2nd request.
    lat_max = 2;
    stall_arm = 1;
    do_req(32'h35A);
    check_fill(32'h35A, "stall");
    chk("stall_cycles", stall_addrs.size(), 3);
    foreach (stall_addrs[i]) chk("stall_addr_stable", stall_addrs[i], word_addr(32'h35A, 1));

    // Error on response 1 only.
    err_mask = 4'b0010;
    do_req(32'h7C1);
    check_fill(32'h7C1, "err");
    err_mask = 4'd0;

    // Reset after two beats, then a clean fill of 0x40.
    do_req(32'h80);
    wait_beats(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    nl = 0;
    foreach (beats[i]) if (beats[i].last) nl++;
    chk("abort_no_last", nl, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_max = 0;
    do_req(32'h40);
    check_fill(32'h40, "after_reset");

    // Randomized fills: address, ready rate, latency, data pattern, errors.
    for (int i = 0; i < 16; i++) begin
      ready_pct = $urandom_range(40, 100);
      lat_max   = $urandom_range(0, 3);
      data_xor  = $urandom;
      err_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      a = $urandom;
      do_req(a);
      check_fill(a, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
